// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg : opcodes, width defaults and scheduler state encoding for the ALU
// Revision: 1.0
// ============================================================================
package alu_pkg;

  localparam int ALU_INPUT_BIT_WIDTH = 8;
  localparam int ALU_INSTR_BIT_WIDTH = 5;
  localparam int ALU_FLAGS_COUNT     = 1;

  localparam logic [ALU_INSTR_BIT_WIDTH-1:0] CODE_INSTR_NOP  = 5'd0;
  localparam logic [ALU_INSTR_BIT_WIDTH-1:0] CODE_INSTR_ADD  = 5'd1;
  localparam logic [ALU_INSTR_BIT_WIDTH-1:0] CODE_INSTR_SUB  = 5'd2;
  localparam logic [ALU_INSTR_BIT_WIDTH-1:0] CODE_INSTR_MUL  = 5'd3;
  localparam logic [ALU_INSTR_BIT_WIDTH-1:0] CODE_INSTR_DIV  = 5'd4;
  localparam logic [ALU_INSTR_BIT_WIDTH-1:0] CODE_INSTR_SHL  = 5'd5;
  localparam logic [ALU_INSTR_BIT_WIDTH-1:0] CODE_INSTR_SHR  = 5'd6;
  localparam logic [ALU_INSTR_BIT_WIDTH-1:0] CODE_INSTR_ROL  = 5'd7;
  localparam logic [ALU_INSTR_BIT_WIDTH-1:0] CODE_INSTR_ROR  = 5'd8;
  localparam logic [ALU_INSTR_BIT_WIDTH-1:0] CODE_INSTR_AND  = 5'd9;
  localparam logic [ALU_INSTR_BIT_WIDTH-1:0] CODE_INSTR_XOR  = 5'd10;
  localparam logic [ALU_INSTR_BIT_WIDTH-1:0] CODE_INSTR_OR   = 5'd11;
  localparam logic [ALU_INSTR_BIT_WIDTH-1:0] CODE_INSTR_NAND = 5'd12;
  localparam logic [ALU_INSTR_BIT_WIDTH-1:0] CODE_INSTR_XNOR = 5'd13;
  localparam logic [ALU_INSTR_BIT_WIDTH-1:0] CODE_INSTR_GTH  = 5'd14;
  localparam logic [ALU_INSTR_BIT_WIDTH-1:0] CODE_INSTR_EQU  = 5'd15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter_2.sv
`default_nettype none
// ============================================================================
// rr_arbiter_2 : two-way round-robin arbiter, one-hot winner (combinational)
// Revision: 1.0
// ============================================================================
module rr_arbiter_2 (
  input  logic [1:0] valid,
  input  logic       last_served,
  output logic [1:0] winner
);

  // On a tie the requester that was not served last wins.
  always_comb begin
    winner = valid;
    if (valid == 2'b11) begin
      winner = last_served ? 2'b01 : 2'b10;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_scheduler.sv
`default_nettype none
// ============================================================================
// alu_scheduler : shares one ALU between two requesters with round-robin
//                 arbitration, bounded wait for Ready and a tagged response.
// Revision: 1.0
// ============================================================================
module alu_scheduler #(
  parameter int INPUT_BIT_WIDTH = alu_pkg::ALU_INPUT_BIT_WIDTH,
  parameter int INSTR_BIT_WIDTH = alu_pkg::ALU_INSTR_BIT_WIDTH,
  parameter int FLAGS_COUNT     = alu_pkg::ALU_FLAGS_COUNT,
  parameter int TIMEOUT_CYCLES  = 64,
  parameter logic [INSTR_BIT_WIDTH-1:0] CODE_INSTR_NOP = '0
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic                       Req0Valid,
  input  logic [INSTR_BIT_WIDTH-1:0] Req0Instruction,
  input  logic [INPUT_BIT_WIDTH-1:0] Req0A,
  input  logic [INPUT_BIT_WIDTH-1:0] Req0B,
  input  logic                       Req1Valid,
  input  logic [INSTR_BIT_WIDTH-1:0] Req1Instruction,
  input  logic [INPUT_BIT_WIDTH-1:0] Req1A,
  input  logic [INPUT_BIT_WIDTH-1:0] Req1B,
  output logic                       Req0Grant,
  output logic                       Req1Grant,
  output logic                       RespValid,
  output logic                       RespId,
  output logic [INPUT_BIT_WIDTH-1:0] RespResultA,
  output logic [INPUT_BIT_WIDTH-1:0] RespResultB,
  output logic [FLAGS_COUNT-1:0]     RespFlags,
  output logic                       RespError,
  output logic [INSTR_BIT_WIDTH-1:0] AluInstruction,
  output logic [INPUT_BIT_WIDTH-1:0] AluInputA,
  output logic [INPUT_BIT_WIDTH-1:0] AluInputB,
  input  logic [INPUT_BIT_WIDTH-1:0] AluResultA,
  input  logic [INPUT_BIT_WIDTH-1:0] AluResultB,
  input  logic [FLAGS_COUNT-1:0]     AluFlags,
  input  logic                       AluReady,
  output logic                       Busy
);

  import alu_pkg::*;

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  sched_state_t state, state_next;
  logic [1:0]   winner;
  logic         last_served;
  logic         serve_id;
  logic [CNT_W-1:0] count;
  logic         timeout_hit;

  rr_arbiter_2 u_arb (
    .valid       ({Req1Valid, Req0Valid}),
    .last_served (last_served),
    .winner      (winner)
  );

  // The count is zero on the first WAIT cycle, so the abort lands on the
  // (TIMEOUT_CYCLES+1)th WAIT cycle: error response TIMEOUT_CYCLES+2 after Grant.
  assign timeout_hit = (count == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (Req0Valid || Req1Valid) state_next = ST_ISSUE;
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT:  if (AluReady || timeout_hit) state_next = ST_RESP;
      ST_RESP:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      last_served    <= 1'b1;
      serve_id       <= 1'b0;
      count          <= '0;
      Req0Grant      <= 1'b0;
      Req1Grant      <= 1'b0;
      RespValid      <= 1'b0;
      RespId         <= 1'b0;
      RespResultA    <= '0;
      RespResultB    <= '0;
      RespFlags      <= '0;
      RespError      <= 1'b0;
      AluInstruction <= CODE_INSTR_NOP;
      AluInputA      <= '0;
      AluInputB      <= '0;
      Busy           <= 1'b0;
    end else begin
      Req0Grant <= 1'b0;
      Req1Grant <= 1'b0;
      RespValid <= 1'b0;
      Busy      <= (state_next != ST_IDLE);
      unique case (state)
        ST_IDLE: begin
          if (winner != 2'b00) begin
            serve_id       <= winner[1];
            last_served    <= winner[1];
            AluInstruction <= winner[1] ? Req1Instruction : Req0Instruction;
            AluInputA      <= winner[1] ? Req1A : Req0A;
            AluInputB      <= winner[1] ? Req1B : Req0B;
            Req0Grant      <= winner[0];
            Req1Grant      <= winner[1];
          end
        end
        ST_ISSUE: count <= '0;
        ST_WAIT: begin
          if (AluReady) begin
            RespResultA    <= AluResultA;
            RespResultB    <= AluResultB;
            RespFlags      <= AluFlags;
            RespError      <= 1'b0;
            RespValid      <= 1'b1;
            RespId         <= serve_id;
            AluInstruction <= CODE_INSTR_NOP;
          end else if (timeout_hit) begin
            RespResultA    <= '0;
            RespResultB    <= '0;
            RespFlags      <= '0;
            RespError      <= 1'b1;
            RespValid      <= 1'b1;
            RespId         <= serve_id;
            AluInstruction <= CODE_INSTR_NOP;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        ST_RESP: ;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_scheduler.sv
`default_nettype none
// ============================================================================
// tb_alu_scheduler : randomized scoreboard bench with a behavioural ALU model
// Revision: 1.0
// ============================================================================
module tb_alu_scheduler;
  import alu_pkg::*;

  localparam int W  = 8;
  localparam int IW = 5;
  localparam int FW = 1;
  localparam int TO = 4;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          Req0Valid = 1'b0, Req1Valid = 1'b0;
  logic [IW-1:0] req_op [2];
  logic [W-1:0]  req_a  [2];
  logic [W-1:0]  req_b  [2];
  logic          Req0Grant, Req1Grant, RespValid, RespId, RespError, Busy;
  logic [W-1:0]  RespResultA, RespResultB, AluInputA, AluInputB;
  logic [FW-1:0] RespFlags;
  logic [IW-1:0] AluInstruction;
  logic [W-1:0]  AluResultA = '0, AluResultB = '0;
  logic [FW-1:0] AluFlags = '0;
  logic          AluReady = 1'b0;

  alu_scheduler #(
    .INPUT_BIT_WIDTH(W), .INSTR_BIT_WIDTH(IW), .FLAGS_COUNT(FW),
    .TIMEOUT_CYCLES(TO), .CODE_INSTR_NOP(CODE_INSTR_NOP)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .Req0Valid(Req0Valid), .Req0Instruction(req_op[0]), .Req0A(req_a[0]), .Req0B(req_b[0]),
    .Req1Valid(Req1Valid), .Req1Instruction(req_op[1]), .Req1A(req_a[1]), .Req1B(req_b[1]),
    .Req0Grant(Req0Grant), .Req1Grant(Req1Grant),
    .RespValid(RespValid), .RespId(RespId), .RespResultA(RespResultA),
    .RespResultB(RespResultB), .RespFlags(RespFlags), .RespError(RespError),
    .AluInstruction(AluInstruction), .AluInputA(AluInputA), .AluInputB(AluInputB),
    .AluResultA(AluResultA), .AluResultB(AluResultB), .AluFlags(AluFlags),
    .AluReady(AluReady), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    logic          id;
    logic [W-1:0]  ra;
    logic [W-1:0]  rb;
    logic [FW-1:0] fl;
    logic          err;
    int            due;
  } exp_t;
  exp_t sb[$];

  // ALU behaviour: 16-bit result split low/high, flag set when result is zero
  int alu_mode = 0;   // 0: Ready after alu_lat WAIT cycles, 1: Ready always high, 2: never Ready
  int alu_lat  = 1;
  int last_served = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_line(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic [2*W+FW-1:0] alu_fn(input logic [IW-1:0] op,
                                               input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] r;
    case (op)
      CODE_INSTR_ADD: r = (2*W)'(a) + (2*W)'(b);
      CODE_INSTR_SUB: r = (2*W)'(a) - (2*W)'(b);
      CODE_INSTR_MUL: r = (2*W)'(a) * (2*W)'(b);
      CODE_INSTR_AND: r = (2*W)'(a & b);
      CODE_INSTR_OR:  r = (2*W)'(a | b);
      CODE_INSTR_XOR: r = (2*W)'(a ^ b);
      default:        r = '0;
    endcase
    return {(r == '0), r};
  endfunction

  function automatic logic [IW-1:0] rand_op();
    case ($urandom_range(0, 5))
      0: return CODE_INSTR_ADD;
      1: return CODE_INSTR_SUB;
      2: return CODE_INSTR_MUL;
      3: return CODE_INSTR_AND;
      4: return CODE_INSTR_OR;
      default: return CODE_INSTR_XOR;
    endcase
  endfunction

  // Behavioural ALU plus WAIT-phase checks against the granted request
  int cnt = 0;
  bit armed = 0;
  logic [IW-1:0] held_op;
  logic [W-1:0]  held_a, held_b;
  always @(negedge Clk) begin
    logic [2*W+FW-1:0] r;
    if (!Reset_n) begin
      armed = 0;
      AluReady = 1'b0;
    end else begin
      if (Req0Grant || Req1Grant) begin
        armed   = 1;
        cnt     = alu_lat;
        held_op = req_op[Req1Grant];
        held_a  = req_a[Req1Grant];
        held_b  = req_b[Req1Grant];
      end else if (armed) begin
        cnt--;
        if (RespValid) armed = 0;
        else begin
          check("alu_ops_held", {AluInstruction, AluInputA, AluInputB}, {held_op, held_a, held_b});
          check("busy_in_wait", Busy, 1);
        end
      end
      r = alu_fn(AluInstruction, AluInputA, AluInputB);
      {AluFlags, AluResultB, AluResultA} = r;
      case (alu_mode)
        0: AluReady = armed && (cnt == 0);
        1: AluReady = 1'b1;
        default: AluReady = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard whenever a response is presented
  bit chk_idle = 0;
  always @(negedge Clk) begin
    exp_t e;
    if (chk_idle) begin
      check("busy_after_resp", Busy, 0);
      chk_idle = 0;
    end
    if (Reset_n && RespValid) begin
      chk_idle = 1;
      if (sb.size() == 0) fail_line("unexpected_resp");
      else begin
        e = sb.pop_front();
        check("resp_id", RespId, e.id);
        check("resp_result_a", RespResultA, e.ra);
        check("resp_result_b", RespResultB, e.rb);
        check("resp_flags", RespFlags, e.fl);
        check("resp_error", RespError, e.err);
        check("resp_cycle", cyc, e.due);
        check("busy_in_resp", Busy, 1);
      end
    end
  end

  task automatic push_exp(input int id, input int g);
    exp_t e;
    e.id = id[0];
    if (alu_mode == 2 || (alu_mode == 0 && alu_lat > TO + 1)) begin
      e.err = 1'b1; e.ra = '0; e.rb = '0; e.fl = '0; e.due = g + TO + 2;
    end else begin
      e.err = 1'b0;
      {e.fl, e.rb, e.ra} = alu_fn(req_op[id], req_a[id], req_b[id]);
      e.due = (alu_mode == 1) ? g + 2 : g + 1 + alu_lat;
    end
    sb.push_back(e);
  endtask

  task automatic wait_grant(output int gid, output bit ok);
    ok = 0;
    gid = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge Clk);
      if (Req0Grant || Req1Grant) begin
        ok = 1;
        gid = Req1Grant ? 1 : 0;
        break;
      end
    end
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge Clk);
      if (sb.size() == 0) begin done = 1; break; end
    end
    if (!done) begin
      fail_line("resp_timeout");
      sb.delete();
    end
    @(negedge Clk);
  endtask

  task automatic do_op(input int id, input logic [IW-1:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    int k, gid;
    bit ok;
    @(negedge Clk);
    req_op[id] = op; req_a[id] = a; req_b[id] = b;
    if (id == 0) Req0Valid = 1'b1; else Req1Valid = 1'b1;
    k = cyc;
    wait_grant(gid, ok);
    if (!ok) fail_line("grant_timeout");
    else begin
      check("grant_onehot", {Req1Grant, Req0Grant}, (id == 1) ? 2'b10 : 2'b01);
      check("grant_latency", cyc - k, 1);
      check("alu_issue_ops", {AluInstruction, AluInputA, AluInputB}, {op, a, b});
      check("busy_in_issue", Busy, 1);
      push_exp(id, cyc);
      last_served = id;
    end
    Req0Valid = 1'b0;
    Req1Valid = 1'b0;
    wait_idle();
  endtask

  task automatic check_reset_outputs();
    check("rst_grant0", Req0Grant, 0);
    check("rst_grant1", Req1Grant, 0);
    check("rst_resp_valid", RespValid, 0);
    check("rst_resp_id", RespId, 0);
    check("rst_resp_a", RespResultA, 0);
    check("rst_resp_b", RespResultB, 0);
    check("rst_resp_flags", RespFlags, 0);
    check("rst_resp_error", RespError, 0);
    check("rst_alu_instr", AluInstruction, CODE_INSTR_NOP);
    check("rst_alu_a", AluInputA, 0);
    check("rst_alu_b", AluInputB, 0);
    check("rst_busy", Busy, 0);
  endtask

  // Both requesters held valid; service must alternate per the last-served model
  task automatic tie_run(input int n);
    int gid, exp_id;
    bit ok;
    @(negedge Clk);
    req_op[0] = CODE_INSTR_SUB; req_a[0] = 8'd15; req_b[0] = 8'd7;
    req_op[1] = CODE_INSTR_OR;  req_a[1] = 8'd15; req_b[1] = 8'd7;
    Req0Valid = 1'b1;
    Req1Valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      wait_grant(gid, ok);
      if (!ok) begin fail_line("tie_grant_timeout"); break; end
      exp_id = (last_served == 1) ? 0 : 1;
      check("tie_grant", {Req1Grant, Req0Grant}, (exp_id == 1) ? 2'b10 : 2'b01);
      push_exp(exp_id, cyc);
      last_served = exp_id;
      @(negedge Clk);
      req_op[exp_id] = rand_op();
      req_a[exp_id]  = W'($urandom);
      req_b[exp_id]  = W'($urandom);
    end
    Req0Valid = 1'b0;
    Req1Valid = 1'b0;
    wait_idle();
  endtask

  initial begin
    int gid;
    bit ok;
    for (int i = 0; i < 2; i++) begin
      req_op[i] = CODE_INSTR_NOP; req_a[i] = '0; req_b[i] = '0;
    end
    repeat (3) @(negedge Clk);
    check_reset_outputs();
    Reset_n = 1'b1;
    @(negedge Clk);

    alu_mode = 0; alu_lat = 1;
    tie_run(6);

    do_op(0, CODE_INSTR_ADD, 8'd15, 8'd7);

    alu_lat = 10;
    do_op(1, CODE_INSTR_MUL, 8'd15, 8'd7);

    alu_mode = 2;
    do_op(0, CODE_INSTR_ADD, 8'd1, 8'd2);
    alu_mode = 0; alu_lat = TO + 1;
    do_op(1, CODE_INSTR_SUB, 8'd9, 8'd3);
    alu_lat = TO;
    do_op(0, CODE_INSTR_XOR, 8'hA5, 8'h5A);

    alu_mode = 1;
    do_op(0, CODE_INSTR_SUB, 8'd3, 8'd9);
    do_op(1, CODE_INSTR_AND, 8'hF0, 8'h3C);

    for (int i = 0; i < 20; i++) begin
      alu_mode = $urandom_range(0, 2);
      alu_lat  = $urandom_range(1, TO + 3);
      do_op($urandom_range(0, 1), rand_op(), W'($urandom), W'($urandom));
    end

    // Reset asserted during WAIT aborts the op without a response
    alu_mode = 2;
    @(negedge Clk);
    req_op[0] = CODE_INSTR_ADD; req_a[0] = 8'd4; req_b[0] = 8'd5;
    Req0Valid = 1'b1;
    wait_grant(gid, ok);
    if (!ok) fail_line("rst_test_grant_timeout");
    Req0Valid = 1'b0;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    check_reset_outputs();
    sb.delete();
    last_served = 1;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (3) @(negedge Clk);
    alu_mode = 0; alu_lat = 2;
    do_op(0, CODE_INSTR_ADD, 8'd200, 8'd100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
